// File: rtl/bioee_clkdiv_pkg.sv
// Shared types and helpers for the BioEE clock-divider scheduler.
// Holds the FSM encoding, the default divider floor and the divider clamp.
package bioee_clkdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT    = 2'd1,
      ST_WAIT_TOG = 2'd2,
      ST_APPLY    = 2'd3
   } state_e;

   localparam int unsigned DIV_MIN_DFLT = 4;
   localparam int unsigned IDX_W        = 3;

   // Divider values must be even and never below the floor.
   function automatic logic [31:0] clamp_div(input logic [31:0] raw, input logic [31:0] dmin);
      logic [31:0] v;
      v = {raw[31:1], 1'b0};
      if (v < dmin) begin
         v = dmin;
      end
      return v;
   endfunction

endpackage

// File: rtl/bioee_rr_arbiter.sv
// Round-robin arbiter, up to 8 requesters; search starts one past the last winner.
// The pointer only moves when the caller accepts the grant.
module bioee_rr_arbiter
   import bioee_clkdiv_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NREQ-1:0]  req_i,
   input  logic             grant_en_i,
   output logic             gnt_valid_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic [IDX_W-1:0] ptr_o
);

   localparam int CW = IDX_W + 1;
   localparam logic [CW-1:0] NREQ_W = CW'(NREQ);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [7:0]       req_pad;
   logic [CW-1:0]    cand;

   always_comb begin
      req_pad     = 8'(req_i);
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      cand        = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = {1'b0, ptr_q} + CW'(k);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (!gnt_valid_o && req_pad[cand[IDX_W-1:0]]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_en_i && gnt_valid_o) begin
         ptr_d = gnt_idx_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/bioee_clkdiv_scheduler.sv
// Arbitrates divider-value requests and applies each new value only on a clkout
// toggle so the shared BioEE divider never produces a runt or stretched period.
//
// state    | meaning
// IDLE     | no grant in flight; div_enable tracks run; latch winner's value
// GRANT    | decide whether to wait for a toggle (divider running) or apply now
// WAIT_TOG | divider running; wait for clkout toggle or timeout
// APPLY    | drive pending value, pulse ack to owner
module bioee_clkdiv_scheduler
   import bioee_clkdiv_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1048576,
   parameter int DIV_MIN = DIV_MIN_DFLT
) (
   input  logic                 clkin,
   input  logic                 rst,
   input  logic                 run,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   req_div,
   output logic [NREQ-1:0]      ack,
   output logic [31:0]          integerdivider,
   output logic                 div_enable,
   input  logic                 div_clkout,
   output logic                 busy,
   output logic [2:0]           owner,
   output logic                 fault
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [31:0]      DIV_MIN_W = 32'(DIV_MIN);

   state_e            state_q, state_d;
   logic [31:0]       pend_q, pend_d;
   logic [31:0]       div_q, div_d;
   logic              en_q, en_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fault_q, fault_d;
   logic              clkout_q;
   logic              tog;
   logic              gnt_valid;
   logic [IDX_W-1:0]  gnt_idx;
   logic [IDX_W-1:0]  ptr;
   logic [31:0]       sel_raw;

   bioee_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk_i       (clkin),
      .rst_i       (rst),
      .req_i       (req),
      .grant_en_i  (state_q == ST_IDLE),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx),
      .ptr_o       (ptr)
   );

   assign tog = div_clkout ^ clkout_q;

   always_comb begin
      sel_raw = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            sel_raw = req_div[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      div_d   = div_q;
      en_d    = en_q;
      ack_d   = '0;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            en_d = run;
            if (gnt_valid) begin
               pend_d  = clamp_div(sel_raw, DIV_MIN_W);
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!en_q) begin
               state_d = ST_APPLY;
            end else begin
               cnt_d   = '0;
               state_d = ST_WAIT_TOG;
            end
         end
         ST_WAIT_TOG: begin
            // A toggle in the same cycle as the last count still counts as on time.
            if (tog) begin
               state_d = ST_APPLY;
            end else if (cnt_q == CNT_LAST) begin
               fault_d = 1'b1;
               state_d = ST_APPLY;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_APPLY: begin
            en_d  = run;
            div_d = pend_q;
            for (int i = 0; i < NREQ; i++) begin
               ack_d[i] = (ptr == IDX_W'(i));
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pend_q   <= DIV_MIN_W;
         div_q    <= DIV_MIN_W;
         en_q     <= 1'b0;
         ack_q    <= '0;
         cnt_q    <= '0;
         fault_q  <= 1'b0;
         clkout_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         div_q    <= div_d;
         en_q     <= en_d;
         ack_q    <= ack_d;
         cnt_q    <= cnt_d;
         fault_q  <= fault_d;
         clkout_q <= div_clkout;
      end
   end

   assign ack            = ack_q;
   assign integerdivider = div_q;
   assign div_enable     = en_q;
   assign busy           = (state_q != ST_IDLE);
   assign owner          = ptr;
   assign fault          = fault_q;

endmodule

// File: tb/tb_bioee_clkdiv_scheduler.sv
// Bench for bioee_clkdiv_scheduler: directed vector table, hand-written corner
// sequences, and randomized batches against a round-robin/clamp reference model.
module tb_bioee_clkdiv_scheduler;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 16;
   localparam int DIV_MIN = 4;

   logic              clkin = 1'b0;
   logic              rst;
   logic              run;
   logic [NREQ-1:0]   req;
   logic [32*NREQ-1:0] req_div;
   logic [NREQ-1:0]   ack;
   logic [31:0]       integerdivider;
   logic              div_enable;
   logic              div_clkout;
   logic              busy;
   logic [2:0]        owner;
   logic              fault;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic        clk_int = 1'b0;
   logic        freeze  = 1'b0;
   logic [31:0] dcnt    = 32'd1;
   int          tog_hist [3] = '{-100, -100, -100};
   int          mptr = 0;

   typedef struct {
      logic [1:0]  req;
      logic [31:0] d0;
      logic [31:0] d1;
      int          exp_owner;
      logic [31:0] exp_div;
   } vec_t;

   vec_t vecs [8];

   bioee_clkdiv_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .DIV_MIN(DIV_MIN)) dut (
      .clkin          (clkin),
      .rst            (rst),
      .run            (run),
      .req            (req),
      .req_div        (req_div),
      .ack            (ack),
      .integerdivider (integerdivider),
      .div_enable     (div_enable),
      .div_clkout     (div_clkout),
      .busy           (busy),
      .owner          (owner),
      .fault          (fault)
   );

   always #5 clkin = ~clkin;

   // Behavioural divider: clkout half-period is integerdivider/2 clkin cycles.
   assign div_clkout = freeze ? 1'b0 : clk_int;

   always @(posedge clkin) begin
      cyc <= cyc + 1;
      if (!div_enable) begin
         dcnt <= 32'd1;
      end else if (dcnt >= (integerdivider >> 1)) begin
         clk_int     <= ~clk_int;
         dcnt        <= 32'd1;
         tog_hist[2] <= tog_hist[1];
         tog_hist[1] <= tog_hist[0];
         tog_hist[0] <= cyc + 1;
      end else begin
         dcnt <= dcnt + 32'd1;
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: no response within bound (cycle %0d)", nm, cyc);
   endtask

   function automatic logic [31:0] clamp_ref(input logic [31:0] d);
      logic [31:0] v;
      v = d - (d % 2);
      if (v < DIV_MIN) v = DIV_MIN;
      return v;
   endfunction

   function automatic int rr_pick(input int m, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (p + k) % NREQ;
         if (((m >> idx) & 1) != 0) return idx;
      end
      return 0;
   endfunction

   task automatic wait_ack(output int acyc, output bit to);
      to   = 1'b1;
      acyc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clkin);
         if (ack != '0) begin
            acyc = cyc;
            to   = 1'b0;
            break;
         end
      end
   endtask

   // mode 0: divider stopped (3-cycle latency); mode 1: running (ack 2 after toggle)
   task automatic run_batch(input logic [1:0] mask, input logic [31:0] d0,
                            input logic [31:0] d1, input int mode);
      int m, refc, acyc, w;
      bit to, hit;
      logic [31:0] ev;
      m       = int'(mask);
      req_div = {d1, d0};
      req     = mask;
      refc    = cyc;
      while (m != 0) begin
         w  = rr_pick(m, mptr);
         ev = clamp_ref(w == 0 ? d0 : d1);
         wait_ack(acyc, to);
         if (to) begin
            fail_now("ack_timeout");
            req = '0;
            return;
         end
         check("ack_onehot", 64'(ack), 64'(1 << w));
         check("div_value", 64'(integerdivider), 64'(ev));
         check("owner", 64'(owner), 64'(w));
         if (mode == 0) begin
            check("stopped_latency", 64'(acyc - refc), 64'd3);
         end else begin
            hit = (tog_hist[0] == acyc - 2) || (tog_hist[1] == acyc - 2) ||
                  (tog_hist[2] == acyc - 2);
            check("tog_to_ack", 64'(hit), 64'd1);
         end
         req[w] = 1'b0;
         m      = m & ~(1 << w);
         mptr   = w;
         refc   = acyc;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acyc, refc, hold_bad, t_prev, fault_cyc, exp_w;
      bit to, ack_seen, got;

      vecs[0] = '{2'b01, 32'd10,         32'd0,  0, 32'd10};
      vecs[1] = '{2'b10, 32'd0,          32'd7,  1, 32'd6};
      vecs[2] = '{2'b01, 32'd3,          32'd0,  0, 32'd4};
      vecs[3] = '{2'b01, 32'd5,          32'd0,  0, 32'd4};
      vecs[4] = '{2'b10, 32'd0,          32'd0,  1, 32'd4};
      vecs[5] = '{2'b01, 32'hFFFF_FFFF,  32'd0,  0, 32'hFFFF_FFFE};
      vecs[6] = '{2'b10, 32'd0,          32'd4,  1, 32'd4};
      vecs[7] = '{2'b10, 32'd0,          32'd9,  1, 32'd8};

      rst = 1'b1; run = 1'b0; req = '0; req_div = '0;
      repeat (2) @(negedge clkin);
      check("rst_div", 64'(integerdivider), 64'd4);
      check("rst_en", 64'(div_enable), 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_owner", 64'(owner), 64'd0);
      check("rst_fault", 64'(fault), 64'd0);
      rst = 1'b0;
      @(negedge clkin);

      // Directed vectors, divider stopped
      for (int v = 0; v < 8; v++) begin
         req_div = {vecs[v].d1, vecs[v].d0};
         req     = vecs[v].req;
         refc    = cyc;
         wait_ack(acyc, to);
         if (to) begin
            fail_now("vec_ack_timeout");
         end else begin
            check("vec_ack", 64'(ack), 64'(1 << vecs[v].exp_owner));
            check("vec_div", 64'(integerdivider), 64'(vecs[v].exp_div));
            check("vec_owner", 64'(owner), 64'(vecs[v].exp_owner));
            check("vec_en", 64'(div_enable), 64'd0);
            check("vec_latency", 64'(acyc - refc), 64'd3);
         end
         req = '0;
         mptr = vecs[v].exp_owner;
         @(negedge clkin);
         check("vec_ack_pulse", 64'(ack), 64'd0);
      end

      // Simultaneous requests: pointer at 1, so requester 0 first
      run_batch(2'b11, 32'd7, 32'd2, 0);
      @(negedge clkin);

      // Fairness with both held continuously
      req_div = {32'd14, 32'd16};
      req     = 2'b11;
      for (int g = 0; g < 4; g++) begin
         exp_w = g % 2;
         wait_ack(acyc, to);
         if (to) begin
            fail_now("fair_timeout");
            break;
         end
         check("fair_ack", 64'(ack), 64'(1 << exp_w));
         check("fair_div", 64'(integerdivider), exp_w == 0 ? 64'd16 : 64'd14);
         check("fair_owner", 64'(owner), 64'(exp_w));
         mptr = exp_w;
      end
      req = '0;
      @(negedge clkin);

      // Running divider: apply 6 over 10 at a toggle
      run_batch(2'b01, 32'd10, 32'd0, 0);
      @(negedge clkin);
      run = 1'b1;
      repeat (2) @(negedge clkin);
      check("en_rise", 64'(div_enable), 64'd1);
      repeat (20) @(negedge clkin);
      req_div  = {32'd6, 32'd10};
      req      = 2'b10;
      hold_bad = 0;
      got      = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clkin);
         if (ack != '0) begin
            got  = 1'b1;
            acyc = cyc;
            break;
         end
         if (integerdivider != 32'd10) hold_bad++;
      end
      req  = '0;
      mptr = 1;
      if (!got) begin
         fail_now("run_ack_timeout");
      end else begin
         check("run_hold", 64'(hold_bad), 64'd0);
         check("run_ack", 64'(ack), 64'd2);
         check("run_div", 64'(integerdivider), 64'd6);
         check("run_owner", 64'(owner), 64'd1);
         check("run_tog_to_ack", 64'(tog_hist[0]), 64'(acyc - 2));
         check("half_old", 64'(tog_hist[0] - tog_hist[1]), 64'd5);
         t_prev = tog_hist[0];
         for (int n = 0; n < 2; n++) begin
            got = 1'b0;
            for (int i = 0; i < 30; i++) begin
               @(negedge clkin);
               if (tog_hist[0] != t_prev) begin
                  got = 1'b1;
                  break;
               end
            end
            if (!got) begin
               fail_now("half_new_timeout");
            end else begin
               check("half_new", 64'(tog_hist[0] - t_prev), 64'd3);
               t_prev = tog_hist[0];
            end
         end
      end

      // Randomized batches against the reference model
      for (int t = 0; t < 40; t++) begin
         logic [1:0] mask;
         logic [31:0] d0, d1;
         @(negedge clkin);
         run = 1'($urandom_range(0, 1));
         repeat (2) @(negedge clkin);
         check("en_follow", 64'(div_enable), 64'(run));
         mask = 2'($urandom_range(1, 3));
         d0   = 32'($urandom_range(0, 24));
         d1   = 32'($urandom_range(0, 24));
         run_batch(mask, d0, d1, run ? 1 : 0);
      end
      check("no_fault_random", 64'(fault), 64'd0);

      // Timeout: clkout frozen with divider enabled
      @(negedge clkin);
      run = 1'b1;
      freeze = 1'b1;
      repeat (3) @(negedge clkin);
      req_div   = {32'd0, 32'd12};
      req       = 2'b01;
      refc      = cyc;
      fault_cyc = -1;
      acyc      = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clkin);
         if (fault && fault_cyc < 0) fault_cyc = cyc;
         if (ack != '0 && acyc < 0) begin
            acyc = cyc;
            check("to_ack", 64'(ack), 64'd1);
            check("to_div", 64'(integerdivider), 64'd12);
            req = '0;
         end
      end
      req  = '0;
      mptr = 0;
      check("fault_latency", 64'(fault_cyc - refc), 64'd18);
      check("to_ack_latency", 64'(acyc - refc), 64'd19);
      check("fault_sticky", 64'(fault), 64'd1);

      // Reset in the middle of WAIT_TOG
      req_div = {32'd0, 32'd20};
      req     = 2'b01;
      repeat (6) @(negedge clkin);
      check("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      req = '0;
      @(negedge clkin);
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_ack", 64'(ack), 64'd0);
      check("mrst_div", 64'(integerdivider), 64'd4);
      check("mrst_en", 64'(div_enable), 64'd0);
      check("mrst_fault", 64'(fault), 64'd0);
      check("mrst_owner", 64'(owner), 64'd0);
      rst      = 1'b0;
      freeze   = 1'b0;
      ack_seen = 1'b0;
      repeat (15) begin
         @(negedge clkin);
         if (ack != '0) ack_seen = 1'b1;
      end
      check("mrst_no_ack", 64'(ack_seen), 64'd0);
      check("mrst_div_kept", 64'(integerdivider), 64'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
